conv_window_gen: RTL

- Upstream feeder for conv_proc.
- Accepts a raster-order pixel stream, one pixel per cycle with gaps allowed.
- Buffers KERNAL_HEIGHT-1 previous image lines and produces a full KERNAL_WIDTH x KERNAL_HEIGHT window plus a valid strobe.
- Its data_mat output connects directly to conv_proc.data_mat.

---
 rtl/conv_pkg.sv | 13 +
 rtl/conv_line_buf.sv | 25 ++
 rtl/conv_window_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared sizes and types for the convolution window generator and conv_proc.
package conv_pkg;

  localparam int KERNAL_WIDTH  = 3;
  localparam int KERNAL_HEIGHT = 3;
  localparam int COLOUR_DEPTH  = 8;

  localparam int WIN_CENTRE =
    (KERNAL_HEIGHT / 2) * KERNAL_WIDTH + KERNAL_WIDTH / 2;

  typedef logic [COLOUR_DEPTH-1:0] pixel_t;

endpackage

// File: rtl/conv_line_buf.sv
// One image line of pixel storage, single address, read-before-write.
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Combinational read returns the old word in the cycle it is overwritten.
  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to KERNAL_WIDTH x KERNAL_HEIGHT sliding window.
// Define CONV_WIN_LAST_EN to add the win_last end-of-frame window flag.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480,
  parameter int KERNAL_WIDTH  = conv_pkg::KERNAL_WIDTH,
  parameter int KERNAL_HEIGHT = conv_pkg::KERNAL_HEIGHT,
  parameter int COLOUR_DEPTH  = conv_pkg::COLOUR_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [COLOUR_DEPTH-1:0] in_pixel,
  output logic [COLOUR_DEPTH-1:0] data_mat [KERNAL_WIDTH*KERNAL_HEIGHT],
  output logic                    win_valid
`ifdef CONV_WIN_LAST_EN
  ,
  output logic                    win_last
`endif
);

  localparam int N   = KERNAL_WIDTH * KERNAL_HEIGHT;
  localparam int NLB = KERNAL_HEIGHT - 1;
  localparam int CW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(KERNAL_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(KERNAL_HEIGHT - 1);

  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;
  logic          win_valid_q, win_valid_d;

  logic [COLOUR_DEPTH-1:0] win_q   [N];
  logic [COLOUR_DEPTH-1:0] win_d   [N];
  logic [COLOUR_DEPTH-1:0] col_vec [KERNAL_HEIGHT];
  logic [COLOUR_DEPTH-1:0] lb_rd   [NLB];
  logic [COLOUR_DEPTH-1:0] lb_wd   [NLB];

  // Start of frame forces the accepted pixel to (0,0).
  always_comb begin
    pos_col = (in_valid && in_sof) ? '0 : col_q;
    pos_row = (in_valid && in_sof) ? '0 : row_q;
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end
  end

  always_comb begin
    lb_wd[0] = in_pixel;
    for (int k = 1; k < NLB; k++) lb_wd[k] = lb_rd[k-1];
  end

  for (genvar k = 0; k < NLB; k++) begin : g_lb
    conv_line_buf #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (COLOUR_DEPTH),
      .AW    (CW)
    ) u_lb (
      .clk   (clk),
      .we    (in_valid),
      .addr  (pos_col),
      .wdata (lb_wd[k]),
      .rdata (lb_rd[k])
    );
  end

  // Top row of the incoming column comes from the deepest buffer.
  always_comb begin
    for (int r = 0; r < KERNAL_HEIGHT - 1; r++)
      col_vec[r] = lb_rd[KERNAL_HEIGHT-2-r];
    col_vec[KERNAL_HEIGHT-1] = in_pixel;
  end

  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int r = 0; r < KERNAL_HEIGHT; r++) begin
        for (int c = 0; c < KERNAL_WIDTH - 1; c++)
          win_d[r*KERNAL_WIDTH+c] = win_q[r*KERNAL_WIDTH+c+1];
        win_d[r*KERNAL_WIDTH+KERNAL_WIDTH-1] = col_vec[r];
      end
    end
  end

  always_comb begin
    win_valid_d = in_valid && (pos_row >= ROW_MIN) && (pos_col >= COL_MIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      for (int i = 0; i < N; i++) win_q[i] <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_q       <= win_d;
    end
  end

  assign data_mat  = win_q;
  assign win_valid = win_valid_q;

`ifdef CONV_WIN_LAST_EN
  logic win_last_q, win_last_d;

  always_comb begin
    win_last_d = in_valid && (pos_row == ROW_LAST) && (pos_col == COL_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) win_last_q <= 1'b0;
    else       win_last_q <= win_last_d;
  end

  assign win_last = win_last_q;
`endif

endmodule
